ecall_service_sequencer: RTL
============================

// Module: ecall_service_sequencer
// PURPOSE
//  Multi-cycle sequencer for ECALL on the single-cycle core. It takes the decoder's ecall
//  flag plus a7/a0 from the register file. It stalls the PC and sequences one service:
//  print a0, read an input word into a0, or halt. It then releases the core to fetch PC+4.
//  It sits beside the Controller; its stall output gates the PC update in IFetch.
// PARAMETERS
//  DISP_HOLD   4   cycles the print service holds the core after disp_valid (>=1)
//  SVC_PRINT   1   a7 code: print a0
//  SVC_READ    5   a7 code: read input word into a0
//  SVC_EXIT    10  a7 code: halt core
// PORTS
//  clk          in   1   core clock
//  rst          in   1   synchronous, active-high reset
//  ecall        in   1   decoder ecall flag for current instruction (combinational)
//  a7_value     in   32  register x17 read value
//  a0_value     in   32  register x10 read value
//  in_data      in   32  input word from switch/UART front end
//  in_valid     in   1   in_data valid; transfer when in_valid && in_ready
//  stall        out  1   1 = hold PC and suppress core reg/mem writes this cycle
//  in_ready     out  1   sequencer accepts in_data
//  disp_data    out  32  word to display
//  disp_valid   out  1   one-cycle strobe: disp_data updated
//  reg_wr_en    out  1   sequencer write to register file (priority over core port)
//  reg_wr_sel   out  5   destination register, constant 5'd10
//  reg_wr_data  out  32  data to write
//  halted       out  1   exit service executed
//  err_svc      out  1   sticky: unsupported a7 code seen
//  svc_count    out  16  completed services, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  States: IDLE, PRINT, READ_WAIT, READ_WB, HALT, RELEASE. Registered state; Moore outputs,
//  except stall in IDLE.
//  Reset: state=IDLE; disp_data=0, disp_valid=0, reg_wr_en=0, reg_wr_data=0, in_ready=0,
//  halted=0, err_svc=0, svc_count=0, hold counter=0. Reset mid-service aborts it; no write issued.
//  stall = (IDLE && ecall) | PRINT | READ_WAIT | READ_WB | HALT. It is 0 in RELEASE.
//  IDLE stall is combinational, so the PC never advances past an ecall in its first cycle.
//  IDLE && ecall, sampled on the edge, dispatches on a7_value (full 32-bit compare):
//   - SVC_PRINT: disp_data<=a0_value, disp_valid<=1 for the next cycle only, counter<=DISP_HOLD-1,
//     go to PRINT.
//   - SVC_READ: go to READ_WAIT.
//   - SVC_EXIT: go to HALT.
//   - Other code: err_svc<=1, go to RELEASE. Total stall is 1 cycle and svc_count is not incremented.
//  PRINT: counter decrements each cycle; at 0 go to RELEASE. Stall length = DISP_HOLD+1 cycles.
//   disp_data holds its value until the next print.
//  READ_WAIT: in_ready=1. On in_valid, capture reg_wr_data<=in_data and go to READ_WB.
//   No timeout; waits indefinitely.
//  READ_WB: reg_wr_en=1, reg_wr_sel=10, reg_wr_data=captured word for exactly 1 cycle, then RELEASE.
//  RELEASE: stall=0, so the PC advances to PC+4 at this edge. ecall is ignored this cycle,
//   which prevents retrigger from the still-visible ecall. svc_count++ (except the
//   unsupported path), then IDLE. Back-to-back ecalls at PC+4 are serviced normally from IDLE.
//  HALT: halted=1 and stall=1 permanently; only rst leaves. svc_count increments on HALT entry.
//  reg_wr_en is 0 in every state except READ_WB. in_ready is 0 outside READ_WAIT.
//  ecall going low while in PRINT, READ_WAIT or READ_WB (not expected while stalled) does not
//  abort the service.
// TESTING
//  1. ecall=1, a7=1, a0=0x1234: disp_valid 1 cycle, disp_data=0x1234, stall high 5 cycles
//     (DISP_HOLD=4), then 1 RELEASE cycle, svc_count=1.
//  2. ecall=1, a7=5; in_valid pulses with 0xCAFE after 7 cycles: in_ready high until the
//     transfer; then reg_wr_en 1 cycle with sel=10, data=0xCAFE; then RELEASE.
//  3. ecall=1, a7=10: halted=1 and stall stays 1 for 100 cycles. rst 1 cycle -> halted=0,
//     stall follows ecall, svc_count=0.
//  4. ecall=1, a7=7: err_svc=1 sticky, stall exactly 1 cycle, svc_count unchanged, no reg write.
//  5. ecall held high through RELEASE: no second service; two ecalls at consecutive PCs
//     -> svc_count=2.
//  6. rst asserted in READ_WAIT after in_valid is accepted: no reg_wr_en ever; all outputs
//     at reset values next cycle.

Source files
------------

// File: rtl/ecall_service_sequencer.sv
// ecall_service_sequencer: stalls the core and sequences one ECALL service (print, read, exit)
module ecall_service_sequencer #(
  parameter int          DISP_HOLD = 4,
  parameter logic [31:0] SVC_PRINT = 32'd1,
  parameter logic [31:0] SVC_READ  = 32'd5,
  parameter logic [31:0] SVC_EXIT  = 32'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall,
  input  logic [31:0] a7_value,
  input  logic [31:0] a0_value,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        stall,
  output logic        in_ready,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic        reg_wr_en,
  output logic [4:0]  reg_wr_sel,
  output logic [31:0] reg_wr_data,
  output logic        halted,
  output logic        err_svc,
  output logic [15:0] svc_count
);
  typedef enum logic [2:0] {IDLE, PRINT, READ_WAIT, READ_WB, HALT, RELEASE} state_t;
  state_t state, next;
  logic [15:0] hold;
  logic skip_count;
  logic take, is_print, is_read, is_exit, is_bad;
  assign take = state == IDLE && ecall;
  assign is_print = a7_value == SVC_PRINT;
  assign is_read = a7_value == SVC_READ;
  assign is_exit = a7_value == SVC_EXIT;
  assign is_bad = !is_print && !is_read && !is_exit;
  assign stall = take || (state != IDLE && state != RELEASE);
  assign in_ready = state == READ_WAIT;
  assign reg_wr_en = state == READ_WB;
  assign reg_wr_sel = 5'd10;
  assign halted = state == HALT;
  // state register; reset aborts any service in flight
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  // next-state: dispatch on a7 from IDLE, RELEASE always returns to IDLE ignoring ecall
  always_comb begin
    next = state;
    case (state)
      IDLE:      if (ecall) next = is_print ? PRINT : is_read ? READ_WAIT : is_exit ? HALT : RELEASE;
      PRINT:     if (hold == 16'd0) next = RELEASE;
      READ_WAIT: if (in_valid) next = READ_WB;
      READ_WB:   next = RELEASE;
      RELEASE:   next = IDLE;
      default:   next = state;
    endcase
  end
  // datapath: display latch, hold counter, read capture, error flag and service count
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_data <= 32'd0;
      disp_valid <= 1'b0;
      reg_wr_data <= 32'd0;
      hold <= 16'd0;
      err_svc <= 1'b0;
      skip_count <= 1'b0;
      svc_count <= 16'd0;
    end else begin
      disp_valid <= take && is_print;
      if (take && is_print) begin
        disp_data <= a0_value;
        hold <= 16'(DISP_HOLD - 1);
      end else if (state == PRINT && hold != 16'd0)
        hold <= hold - 16'd1;
      if (state == READ_WAIT && in_valid)
        reg_wr_data <= in_data;
      if (take && is_bad)
        err_svc <= 1'b1;
      if (take)
        skip_count <= is_bad;
      if ((state == RELEASE && !skip_count) || (take && is_exit))
        svc_count <= svc_count + 16'd1;
    end
  end
endmodule
